// File: rtl/operand_debounce.sv
// operand_debounce: synchronise and per-bit debounce two raw pad vectors into clean operands (DEBOUNCE_BYPASS_EN skips the debounce counters)
module operand_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] a_raw,
  input  logic [WIDTH-1:0] b_raw,
  output logic [WIDTH-1:0] a_clean,
  output logic [WIDTH-1:0] b_clean,
  output logic             upd,
  output logic             busy
);
  localparam int N = 2 * WIDTH;
  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [N-1:0] w_s;
  logic [N-1:0] r_clean;
  logic [N-1:0] w_flip;
  logic         r_upd;
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign a_clean = r_clean[WIDTH-1:0];
  assign b_clean = r_clean[N-1:WIDTH];
  assign upd     = r_upd;
  // Synchroniser chain keeps shifting regardless of ena
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    else begin
      r_sync[0] <= {b_raw, a_raw};
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
`ifdef DEBOUNCE_BYPASS_EN
  assign w_flip = w_s ^ r_clean;
  assign busy   = 1'b0;
  // Clean follows the synchronised input directly while enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_clean <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= ena && |w_flip;
      if (ena) r_clean <= w_s;
    end
`else
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] r_cnt     [N];
  logic [CW-1:0] w_cnt_nxt [N];
  logic [N-1:0]  w_cnting;
  logic          r_busy;
  assign busy = r_busy;
  // Per bit: a match clears the count, a mismatch reaching LAST flips clean, otherwise count up
  always_comb begin
    w_flip   = '0;
    w_cnting = '0;
    for (int i = 0; i < N; i++) begin
      w_flip[i]    = (w_s[i] != r_clean[i]) && (r_cnt[i] == LAST);
      w_cnt_nxt[i] = (w_s[i] == r_clean[i] || w_flip[i]) ? '0 : r_cnt[i] + CW'(1);
      w_cnting[i]  = w_cnt_nxt[i] != '0;
    end
  end
  // Counters, clean outputs and busy advance only while enabled; upd is a one-cycle strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      r_clean <= '0;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_upd <= ena && |w_flip;
      if (ena) begin
        for (int i = 0; i < N; i++) r_cnt[i] <= w_cnt_nxt[i];
        r_clean <= r_clean ^ w_flip;
        r_busy  <= |w_cnting;
      end
    end
`endif
endmodule

// File: tb/tb_operand_debounce.sv
// tb_operand_debounce: directed latency/glitch/freeze/reset scenarios plus randomized run against a streak-count reference model
module tb_operand_debounce;
  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 16;
  localparam int N = 2 * W;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [W-1:0] a_raw = '0;
  logic [W-1:0] b_raw = '0;
  logic [W-1:0] a_clean;
  logic [W-1:0] b_clean;
  logic         upd;
  logic         busy;
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] m_sync [$];
  logic [N-1:0] m_clean;
  int           m_streak [N];
  logic         m_upd;
  logic         m_busy;

  operand_debounce #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean), .b_clean(b_clean), .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_sync = {};
    repeat (S) m_sync.push_back('0);
    m_clean = '0;
    for (int i = 0; i < N; i++) m_streak[i] = 0;
    m_upd = 1'b0;
    m_busy = 1'b0;
  endtask

  // One clock edge: the model treats a clean bit as flipping after D enabled mismatch cycles in a row
  task automatic tick();
    logic [N-1:0] raw, s, flip;
    logic         en;
    raw = {b_raw, a_raw};
    en = ena;
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      s = m_sync[0];
      flip = '0;
      if (en) begin
        m_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (s[i] != m_clean[i]) begin
            m_streak[i]++;
            if (m_streak[i] == D) begin
              flip[i] = 1'b1;
              m_streak[i] = 0;
            end
          end else m_streak[i] = 0;
          if (m_streak[i] != 0) m_busy = 1'b1;
        end
        m_clean = m_clean ^ flip;
      end
      m_upd = |flip;
      m_sync.push_back(raw);
      void'(m_sync.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    ena = 1'b1;
    a_raw = '0;
    b_raw = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_raw = 8'hFF;
    b_raw = 8'hFF;
    model_clear();
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if ({a_clean, b_clean, upd, busy} !== 18'h0) begin
        errors++;
        $display("FAIL reset: a_clean=%h b_clean=%h upd=%b busy=%b, want all 0", a_clean, b_clean, upd, busy);
      end
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    a_raw = 8'hA5;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (a_clean !== (e >= 18 ? 8'hA5 : 8'h00) || upd !== (e == 18) || busy !== (e >= 3 && e <= 17)) begin
        errors++;
        $display("FAIL latency edge %0d: a_clean=%h upd=%b busy=%b, want %h %b %b", e, a_clean, upd, busy,
                 e >= 18 ? 8'hA5 : 8'h00, e == 18, e >= 3 && e <= 17);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    b_raw = 8'h01;
    for (int e = 1; e <= 22; e++) begin
      if (e == 11) b_raw = 8'h00;
      tick();
      checks++;
      if (b_clean !== 8'h00 || upd !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge %0d: b_clean=%h upd=%b, want 00 0", e, b_clean, upd);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch busy: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_ena_freeze();
    int pulses;
    pulses = 0;
    do_reset();
    a_raw = 8'h0F;
    for (int e = 1; e <= 26; e++) begin
      ena = !(e >= 10 && e <= 14);
      tick();
      pulses += int'(upd);
      checks++;
      if (a_clean !== (e >= 23 ? 8'h0F : 8'h00) || upd !== (e == 23)) begin
        errors++;
        $display("FAIL ena_freeze edge %0d: a_clean=%h upd=%b, want %h %b", e, a_clean, upd,
                 e >= 23 ? 8'h0F : 8'h00, e == 23);
      end
    end
    ena = 1'b1;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ena_freeze pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_raw = 8'h3C;
    repeat (11) tick();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({a_clean, b_clean, upd, busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid async: a_clean=%h upd=%b busy=%b, want 00 0 0", a_clean, upd, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (a_clean !== (e >= 18 ? 8'h3C : 8'h00) || upd !== (e == 18)) begin
        errors++;
        $display("FAIL reset_mid edge %0d: a_clean=%h upd=%b, want %h %b", e, a_clean, upd,
                 e >= 18 ? 8'h3C : 8'h00, e == 18);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a;
    do_reset();
    a_raw = 8'h01;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 1) a_raw = 8'h03;
      exp_a = e >= 19 ? 8'h03 : (e >= 18 ? 8'h01 : 8'h00);
      checks++;
      if (a_clean !== exp_a || upd !== (e == 18 || e == 19)) begin
        errors++;
        $display("FAIL back_to_back edge %0d: a_clean=%h upd=%b, want %h %b", e, a_clean, upd, exp_a, e == 18 || e == 19);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        a_raw = a_raw ^ W'($urandom_range(0, 255) & $urandom_range(0, 255));
        b_raw = b_raw ^ W'($urandom_range(0, 255) & $urandom_range(0, 255));
        hold = $urandom_range(1, 40);
      end
      hold--;
      ena = $urandom_range(0, 9) != 0;
      if (c == 2000) begin
        rst_n = 1'b0;
        model_clear();
      end
      if (c == 2003) rst_n = 1'b1;
      tick();
      checks++;
      if ({b_clean, a_clean} !== m_clean || upd !== m_upd || busy !== m_busy) begin
        errors++;
        $display("FAIL random cycle %0d: clean=%h upd=%b busy=%b, want %h %b %b", c, {b_clean, a_clean}, upd, busy,
                 m_clean, m_upd, m_busy);
      end
    end
    ena = 1'b1;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_glitch();
    test_ena_freeze();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
